// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package wb_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // One retiring result headed for the register file.
    typedef struct packed {
        logic [4:0]              rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } wb_grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set (new writer issued) beats a clear (older writer retiring) on the
// same register, since the issued instruction is the younger one.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    // Next busy vector: set wins over clear, x0 is never busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (set_en && (set_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_en && (clr_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy register, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges the ALU and mem/muldiv result streams onto the
// single register-file write port, with starvation protection for the mem
// path and a pending-write scoreboard for hazard detection.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int NREGS        = NREGS_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             mem_ready,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic [4:0]       A3,
    output logic             WE3,
    output logic [XLEN-1:0]  WD3,
    output logic [NREGS-1:0] busy
);

    localparam int         IDX_W      = $clog2(NREGS);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    wb_grant_e       grant_s;
    logic            xfer_s;
    logic [4:0]      xfer_rd_s;
    logic [XLEN-1:0] xfer_data_s;
    logic            set_en_s;

    logic [3:0]      starve_d, starve_q;
    logic            we_d, we_q;
    logic [4:0]      a3_d, a3_q;
    logic [XLEN-1:0] wd_d, wd_q;

    // Grant: a starved mem result first, then ALU, then mem.
    always_comb begin
        grant_s = GNT_NONE;
        if (mem_valid && (starve_q == STARVE_MAX)) begin
            grant_s = GNT_MEM;
        end else if (alu_valid) begin
            grant_s = GNT_ALU;
        end else if (mem_valid) begin
            grant_s = GNT_MEM;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    assign alu_ready = (grant_s == GNT_ALU);
    assign mem_ready = (grant_s == GNT_MEM);

    // Select the accepted result (grant implies the source is valid).
    always_comb begin
        xfer_s      = 1'b0;
        xfer_rd_s   = 5'd0;
        xfer_data_s = {XLEN{1'b0}};
        case (grant_s)
            GNT_ALU: begin
                xfer_s      = 1'b1;
                xfer_rd_s   = alu_rd;
                xfer_data_s = alu_data;
            end
            GNT_MEM: begin
                xfer_s      = 1'b1;
                xfer_rd_s   = mem_rd;
                xfer_data_s = mem_data;
            end
            default: begin
                xfer_s      = 1'b0;
                xfer_rd_s   = 5'd0;
                xfer_data_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Next write-port state: writes to x0 are accepted but dropped,
    // and address/data hold when nothing is written.
    always_comb begin
        we_d = xfer_s && (xfer_rd_s != 5'd0);
        if (we_d) begin
            a3_d = xfer_rd_s;
            wd_d = xfer_data_s;
        end else begin
            a3_d = a3_q;
            wd_d = wd_q;
        end
    end

    // Starve counter: counts refused mem cycles, saturating at the limit.
    always_comb begin
        if (mem_valid && !mem_ready) begin
            if (starve_q >= STARVE_MAX) begin
                starve_d = STARVE_MAX;
            end else begin
                starve_d = starve_q + 4'd1;
            end
        end else begin
            starve_d = 4'd0;
        end
    end

    // Write-port and starve-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            a3_q     <= 5'd0;
            wd_q     <= {XLEN{1'b0}};
            starve_q <= 4'd0;
        end else begin
            we_q     <= we_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            starve_q <= starve_d;
        end
    end

    assign WE3 = we_q;
    assign A3  = a3_q;
    assign WD3 = wd_q;

    assign set_en_s = issue_valid && (issue_rd != 5'd0);

    wb_scoreboard #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en_s),
        .set_idx (issue_rd[IDX_W-1:0]),
        .clr_en  (we_d),
        .clr_idx (xfer_rd_s[IDX_W-1:0]),
        .busy    (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of per-cycle vectors
// with hand-derived expectations, plus a reset-in-traffic sequence.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        mv;  logic [4:0] mrd; logic [31:0] md;
        logic        iv;  logic [4:0] ird;
        logic        ear; logic       emr;
        logic        ewe; logic [4:0] ea3; logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] busy;
    } out_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    out_t exp_q [$];

    regfile_wb_arbiter #(.XLEN(32), .NREGS(32), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .A3          (A3),
        .WE3         (WE3),
        .WD3         (WD3),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird,
        input logic ear, input logic emr,
        input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
        input logic [31:0] ebusy);
        vec_t v;
        v.av = av;   v.ard = ard; v.ad = ad;
        v.mv = mv;   v.mrd = mrd; v.md = md;
        v.iv = iv;   v.ird = ird;
        v.ear = ear; v.emr = emr;
        v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd;
        v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        alu_valid   = v.av; alu_rd = v.ard; alu_data = v.ad;
        mem_valid   = v.mv; mem_rd = v.mrd; mem_data = v.md;
        issue_valid = v.iv; issue_rd = v.ird;
    endtask

    initial begin
        out_t o;

        //            alu                      mem                           issue       rdy        WE  A3     WD3               busy
        vecs[0]  = mk(1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0,          1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0,          32'h0000_0020);
        vecs[1]  = mk(1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h1234_5678,  32'h0000_0000);
        vecs[2]  = mk(1'b1, 5'd1,  32'd10,       1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1,  32'd10,         32'h0000_0000);
        vecs[3]  = mk(1'b1, 5'd2,  32'd20,       1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2,  32'd20,         32'h0000_0000);
        vecs[4]  = mk(1'b1, 5'd3,  32'd30,       1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3,  32'd30,         32'h0000_0000);
        vecs[5]  = mk(1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0,          1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3,  32'd30,         32'h0000_0000);
        vecs[6]  = mk(1'b0, 5'd0,  32'd0,        1'b1, 5'd0, 32'hFFFF_FFFF,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3,  32'd30,         32'h0000_0000);
        vecs[7]  = mk(1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0,          1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd3,  32'd30,         32'h0000_0080);
        vecs[8]  = mk(1'b1, 5'd7,  32'd77,       1'b0, 5'd0, 32'd0,          1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7,  32'd77,         32'h0000_0080);
        vecs[9]  = mk(1'b1, 5'd7,  32'd78,       1'b0, 5'd0, 32'd0,          1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 5'd7,  32'd78,         32'h0000_0100);
        vecs[10] = mk(1'b1, 5'd10, 32'h0000_000A, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_000A,  32'h0000_0100);
        vecs[11] = mk(1'b1, 5'd11, 32'h0000_000B, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_000B,  32'h0000_0100);
        vecs[12] = mk(1'b1, 5'd12, 32'h0000_000C, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_000C,  32'h0000_0100);
        vecs[13] = mk(1'b1, 5'd13, 32'h0000_000D, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_000D,  32'h0000_0100);
        vecs[14] = mk(1'b1, 5'd14, 32'h0000_000E, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9,  32'hDEAD_BEEF,  32'h0000_0100);
        vecs[15] = mk(1'b1, 5'd14, 32'h0000_000E, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0000_000E,  32'h0000_0100);
        vecs[16] = mk(1'b1, 5'd15, 32'h0000_000F, 1'b1, 5'd9, 32'd1,         1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_000F,  32'h0000_0300);
        vecs[17] = mk(1'b0, 5'd0,  32'd0,        1'b1, 5'd9, 32'd1,          1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9,  32'd1,          32'h0000_0100);

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        chk1("reset_WE3", WE3, 1'b0);
        chk("reset_A3", {27'd0, A3}, 32'd0);
        chk("reset_WD3", WD3, 32'd0);
        chk("reset_busy", busy, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: ready is combinational, write port follows one edge later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk1($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].ear);
            chk1($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].emr);
            o.we = vecs[i].ewe; o.a3 = vecs[i].ea3; o.wd = vecs[i].ewd; o.busy = vecs[i].ebusy;
            exp_q.push_back(o);
            @(posedge clk);
            #1;
            o = exp_q.pop_front();
            chk1($sformatf("v%0d_WE3", i), WE3, o.we);
            chk($sformatf("v%0d_A3", i), {27'd0, A3}, {27'd0, o.a3});
            chk($sformatf("v%0d_WD3", i), WD3, o.wd);
            chk($sformatf("v%0d_busy", i), busy, o.busy);
        end

        // Build up mem starvation, then reset in the middle of traffic.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0055;
        mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 32'h0000_0099;
        issue_valid = 1'b1; issue_rd = 5'd21;
        @(posedge clk);
        #1;
        chk1("pre_rst_WE3", WE3, 1'b1);
        chk("pre_rst_busy", busy, 32'h0020_0100);
        @(negedge clk);
        alu_rd = 5'd23;
        issue_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd22;
        #1;
        chk1("rst_async_WE3", WE3, 1'b0);
        chk("rst_async_A3", {27'd0, A3}, 32'd0);
        chk("rst_async_WD3", WD3, 32'd0);
        chk("rst_async_busy", busy, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("in_rst%0d_WE3", c), WE3, 1'b0);
            chk($sformatf("in_rst%0d_busy", c), busy, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b0;

        // After reset the starve count restarts: four ALU wins, then mem.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
            end
            alu_rd = 5'(23 + k);
            #1;
            chk1($sformatf("post_rst%0d_alu_ready", k), alu_ready, (k != 4));
            chk1($sformatf("post_rst%0d_mem_ready", k), mem_ready, (k == 4));
            @(posedge clk);
            #1;
            chk1($sformatf("post_rst%0d_WE3", k), WE3, 1'b1);
            chk($sformatf("post_rst%0d_A3", k), {27'd0, A3}, (k == 4) ? 32'd9 : 32'(23 + k));
            chk($sformatf("post_rst%0d_WD3", k), WD3, (k == 4) ? 32'h0000_0099 : 32'h0000_0055);
        end

        // Refused ALU result drains once mem is gone, then the port goes idle.
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        chk1("drain_alu_ready", alu_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("drain_A3", {27'd0, A3}, 32'd27);
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk1("idle_WE3", WE3, 1'b0);
        chk("idle_A3_hold", {27'd0, A3}, 32'd27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writer end of the register-file write port (A3/WE3/WD3). Merges retiring results from the single-cycle ALU path and the variable-latency memory/muldiv path onto that one write port, with valid/ready handshakes and starvation protection. Also keeps a per-register pending-write scoreboard that decode/hazard logic reads to stall on RAW dependencies. Sits between execute/memory stages and the register file.

Parameters:
XLEN, 32, data width of results and of WD3.
NREGS, 32, architectural register count; rd width is log2(NREGS).
STARVE_LIMIT, 4, consecutive cycles the mem path may be refused before it gets forced priority (legal range 1..15).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, asynchronous, active-high.
alu_valid  in  1  ALU result offered.
alu_rd  in  5  ALU destination register.
alu_data  in  XLEN  ALU result.
alu_ready  out  1  ALU result accepted this cycle.
mem_valid  in  1  mem/muldiv result offered.
mem_rd  in  5  mem/muldiv destination register.
mem_data  in  XLEN  mem/muldiv result.
mem_ready  out  1  mem result accepted this cycle.
issue_valid  in  1  decode issues an instruction that writes a register.
issue_rd  in  5  destination of the issued instruction.
A3  out  5  register-file write address.
WE3  out  1  register-file write enable.
WD3  out  XLEN  register-file write data.
busy  out  NREGS  bit i = write to xi pending; bit 0 always 0.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: A3=0, WE3=0, WD3=0, busy=0, starve counter=0.
- Grant is combinational, one transfer per cycle:
  - If mem_valid and starve_cnt==STARVE_LIMIT, grant mem.
  - Else if alu_valid, grant alu.
  - Else if mem_valid, grant mem.
  - Else no grant.
- Ready outputs:
  - alu_ready = (grant==alu).
  - mem_ready = (grant==mem).
  - Transfer = valid & ready. A ready is never raised for a source whose valid is low.
- Sources hold rd/data stable while valid=1 and ready=0. Sources do not drop valid before acceptance.
- Output stage is registered, latency 1:
  - On a transfer with rd!=0: next cycle WE3=1, A3=rd, WD3=data.
  - On a transfer with rd==0: handshake completes and the data is discarded; next cycle WE3=0.
  - With no transfer: WE3=0. A3 and WD3 hold their last values.
- Starve counter (4 bit):
  - mem_valid & !mem_ready: increment, saturating at STARVE_LIMIT.
  - mem transfer or mem_valid=0: clear to 0.
  - So mem waits at most STARVE_LIMIT cycles. The ALU may then be refused for 1 cycle.
- Scoreboard:
  - issue_valid & issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - Any transfer with rd!=0 clears busy[rd] at the same edge the registered write is launched.
  - Set and clear of the same register in one cycle: set wins, because the new instruction is younger.
  - Set and clear of different registers both take effect.
  - busy[0] is constant 0.
  - Setting an already-busy bit is legal. A second in-flight writer to the same rd is the issuer's concern; the bit stays 1.
- Simultaneous alu_valid and mem_valid with the same rd: the granted one is written first, the other in a later cycle. The arbiter does not reorder further.
- Reset mid-operation: pending handshakes are abandoned, WE3 drops asynchronously, busy clears. No write is issued after reset deasserts until a new transfer.

Decomposition:
- Package wb_pkg:
  - XLEN_DEFAULT and NREGS_DEFAULT.
  - typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
  - enum wb_grant_e {GNT_NONE, GNT_ALU, GNT_MEM}.
- Sub-module wb_scoreboard: busy vector with set/clear ports and set-wins rule, instantiated once.
- Grant logic, starve counter and output register stay in the top module.

Test Plan:
1. Reset: assert rst for 3 cycles mid-traffic, then release -> WE3=0, busy=0 immediately on rst rising; no WE3 until the next handshake.
2. ALU only: alu_valid=1, rd=5, data=32'h1234_5678 -> alu_ready=1 the same cycle; next cycle WE3=1, A3=5, WD3=32'h12345678; busy[5] set by a prior issue is cleared at that edge.
3. Contention: alu_valid held 1 with new rd each cycle, mem_valid=1, rd=9, data=32'hDEADBEEF, STARVE_LIMIT=4 -> mem_ready=0 for 4 cycles, mem_ready=1 and alu_ready=0 on the 5th; next cycle A3=9, WD3=32'hDEADBEEF; counter returns to 0.
4. x0 discard: mem_valid=1, rd=0, data=32'hFFFFFFFF -> mem_ready=1; next cycle WE3=0; busy[0] stays 0.
5. Scoreboard race: busy[7]=1; same cycle issue_valid, issue_rd=7 and ALU transfer rd=7 -> busy[7] remains 1 and WE3=1, A3=7 next cycle. Repeat with issue_rd=8 -> busy[7]=0, busy[8]=1.
6. Back-to-back: alu transfers rd=1,2,3 in consecutive cycles with data 10,20,30 -> WE3 held 1 for 3 cycles with A3/WD3 = 1/10, 2/20, 3/30.
